// File: rtl/alu_result_stage.sv
// alu_result_stage
//
// Registered result stage behind the 32-bit ALU. Accepts one result per cycle
// over valid/ready. Each result is normalised and pushed into a 2-entry FIFO
// toward writeback. Also maintains the NZCV status register, which updates
// only the flags the producing op defines.
//
// Optional feature macro: ALU_STICKY_V_EN
//   When defined, V is sticky: it ORs in each new overflow, and only flag_clr
//   clears it. A same-cycle overflow still beats the clear.
//   When undefined, V is overwritten by V-updating ops, and flag_clr clears
//   only op_err.
//
// Ports
//   clk, reset_n        clock, async active-low reset
//   in_valid/in_ready   upstream handshake (in_ready registered, high iff count < 2)
//   alu_op              4-bit ALU control code of this result
//   alu_result          32-bit ALU output
//   alu_c/v/n/z         ALU flags (alu_n and alu_z are unused; N/Z are recomputed)
//   out_valid/out_ready downstream handshake on the FIFO head
//   out_result, out_op  normalised result and op code at FIFO head
//   nzcv                status register {N,Z,C,V}
//   op_err              sticky illegal-op indication
//   flag_clr            synchronous clear of op_err (and of V when sticky)

module alu_result_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_c,
  input  logic        alu_v,
  input  logic        alu_n,
  input  logic        alu_z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_op,
  output logic [3:0]  nzcv,
  output logic        op_err,
  input  logic        flag_clr
);

  // The FIFO uses 1-bit pointers, so only DEPTH == 2 is meaningful.
  localparam int unsigned CntW = 2;

  logic [31:0]     res_q [DEPTH];
  logic [3:0]      op_q  [DEPTH];
  logic            wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            in_ready_q;
  logic [3:0]      nzcv_q, nzcv_d;
  logic            op_err_q, op_err_d;

  logic            push, pop;
  logic [31:0]     norm_result;
  logic            illegal;
  logic            v_upd;
  logic            v_d;
  logic            res_zero;

  // alu_n and alu_z are ignored: N and Z are derived from the result here.
  logic unused_flags;
  assign unused_flags = alu_n ^ alu_z;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid & out_ready;

  assign res_zero = (alu_result == 32'h0);

  // Count and registered ready.
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Normalisation and flag next-state.
  always_comb begin
    nzcv_d      = nzcv_q;
    norm_result = alu_result;
    illegal     = 1'b0;
    v_upd       = 1'b0;
    case (alu_op)
      // Logic ops: N, Z only.
      4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1100: begin
        nzcv_d[3] = alu_result[31];
        nzcv_d[2] = res_zero;
      end
      // Add/sub: all four flags.
      4'b0010, 4'b0110, 4'b1010, 4'b1110: begin
        nzcv_d[3] = alu_result[31];
        nzcv_d[2] = res_zero;
        nzcv_d[1] = alu_c;
        v_upd     = 1'b1;
      end
      // Shift left: N, Z, C.
      4'b1101: begin
        nzcv_d[3] = alu_result[31];
        nzcv_d[2] = res_zero;
        nzcv_d[1] = alu_c;
      end
      // SLT signed/unsigned: result bit 31 carries the comparison outcome.
      4'b1111, 4'b0101: begin
        norm_result = {31'b0, alu_result[31]};
        nzcv_d[2]   = ~alu_result[31];
      end
      default: begin
        norm_result = 32'h0;
        illegal     = 1'b1;
      end
    endcase

    if (!push) begin
      nzcv_d[3:1] = nzcv_q[3:1];
    end

`ifdef ALU_STICKY_V_EN
    // New overflow wins over a same-cycle clear.
    v_d = (flag_clr ? 1'b0 : nzcv_q[0]) | (push & v_upd & alu_v);
`else
    v_d = (push & v_upd) ? alu_v : nzcv_q[0];
`endif
    nzcv_d[0] = v_d;

    op_err_d = flag_clr ? 1'b0 : (op_err_q | (push & illegal));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        res_q[i] <= 32'h0;
        op_q[i]  <= 4'h0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      nzcv_q     <= 4'b0100;
      op_err_q   <= 1'b0;
    end else begin
      if (push) begin
        res_q[wr_ptr_q] <= norm_result;
        op_q[wr_ptr_q]  <= alu_op;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q    <= count_d;
      in_ready_q <= (count_d < 2'd2);
      nzcv_q     <= nzcv_d;
      op_err_q   <= op_err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = (count_q != '0);
  assign out_result = res_q[rd_ptr_q];
  assign out_op     = op_q[rd_ptr_q];
  assign nzcv       = nzcv_q;
  assign op_err     = op_err_q;

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered result stage directly downstream of the 32-bit ALU. Accepts one ALU result per cycle (result, C/V/N/Z, and the 4-bit ALU control code that produced it) over a valid/ready handshake. Buffers results in a 2-entry FIFO toward the writeback consumer. Maintains the architectural NZCV status register, updating only the flags each operation actually defines.

## Interface
- `DEPTH`, 2 — FIFO entries. Only 2 is supported.
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `reset_n`  in  1  — asynchronous active-low reset.
- `in_valid`  in  1  — upstream ALU result valid.
- `in_ready`  out  1  — stage can accept; registered, high iff FIFO count < 2.
- `alu_op`  in  4  — ALU control code for this result.
- `alu_result`  in  32  — ALU output.
- `alu_c`, `alu_v`, `alu_n`, `alu_z`  in  1 each — ALU flags; may be X for ops that leave them undefined.
- `out_valid`  out  1  — FIFO head valid.
- `out_ready`  in  1  — downstream accepts head.
- `out_result`  out  32  — normalised result at FIFO head.
- `out_op`  out  4  — op code at FIFO head.
- `nzcv`  out  4  — status register {N,Z,C,V}.
- `op_err`  out  1  — sticky; set by an illegal op code.
- `flag_clr`  in  1  — synchronous clear of `op_err`, and of V when the sticky-V feature is compiled in.

## Operation
- Push: `in_valid & in_ready`. Pop: `out_valid & out_ready`. Push and pop in the same cycle are both allowed, including at count 1. At count 2, `in_ready` is 0, so no push occurs.
- FIFO holds {op, normalised result}. Wrap-around uses 1-bit read and write pointers plus a 2-bit count (0..2).
- Result normalisation, applied at push:
  - 1111 (SLT signed) and 0101 (SLT unsigned): result = {31'b0, alu_result[31]}.
  - Illegal ops: result = 0.
  - All other ops: result passed unchanged.
- Flag update at push (held = previous value kept; X inputs must never reach `nzcv`):
  - 0000 AND, 0001 OR, 0011 XOR, 0111 NAND, 1100 NOR: update N, Z; hold C, V.
  - 0010, 0110, 1010, 1110 (add/sub): update N, Z, C, V from the ALU.
  - 1101 (shift left): update N, Z, C; hold V.
  - 1111, 0101 (SLT): Z = ~alu_result[31]; hold N, C, V.
  - Illegal (0100, 1000, 1001, 1011): hold all flags; set `op_err`.
- Z for logic, add/sub and shift ops is recomputed here as (alu_result == 0). `alu_z` is ignored.
- `flag_clr` has priority over a same-cycle `op_err` set: the clear wins.

## Timing
- Reset values: `out_valid`=0, `out_result`=0, `out_op`=0, `nzcv`=4'b0100 (Z=1), `op_err`=0, `in_ready`=1, count=0, pointers=0.
- Latency: a result pushed in cycle t is visible at `out_result` with `out_valid`=1 in cycle t+1 if the FIFO was empty.
- Flags from a push in cycle t are visible on `nzcv` in cycle t+1. Flags update at push, independent of pop.
- `in_ready` is a registered function of next count. It is deasserted the cycle after the push that fills the FIFO, and reasserted the cycle after a pop from full.
- `out_result`/`out_op` hold stable while `out_valid & ~out_ready`.
- Reset asserted mid-operation flushes all entries immediately, with no handshake. Outputs return to reset values asynchronously.

## Configuration
- `ALU_STICKY_V_EN` defined: on every V-updating op, status V = V_prev | new V. V clears only on `flag_clr` (a same-cycle overflow still wins over the clear for V).
- `ALU_STICKY_V_EN` undefined: V is overwritten per the update rules. `flag_clr` affects only `op_err`.

## Test plan
- Reset, then push op 0010, A+B result 32'h0000_0000 with alu_c=1 -> next cycle `nzcv`=4'b0110, `out_result`=0, `out_valid`=1.
- Push 1010 giving V=1, then 0000 with C/V driven X and result 32'h8000_0000 -> `nzcv`=4'b1001 (N=1, Z=0, C held 0, V held 1).
- Push 1111 with alu_result=32'h8000_1234 -> `out_result`=32'h0000_0001, Z=0; with alu_result[31]=0 -> `out_result`=0, Z=1.
- Hold `out_ready`=0 and push three back-to-back results -> first two accepted, `in_ready`=0 from the cycle after the second push. Release `out_ready` -> results drain in order, and push and pop occur in the same cycle at count 1.
- Push op 1001 -> `out_result`=0, flags unchanged, `op_err`=1. Pulse `flag_clr` -> `op_err`=0 next cycle.
- With `ALU_STICKY_V_EN`: 1010 with overflow, then 1010 without -> V stays 1 until `flag_clr`. Without the macro, V=0 after the second op.
